// File: rtl/execute.sv
// Execute stage of the 16-bit pipelined CPU.
// Computes the ALU result / memory address, branch or jump target, store
// data and signed comparison flags. Everything lands in the EX/MEM pipeline
// register, so each output is valid one cycle after its inputs are sampled.
// There is no handshake: one instruction is accepted on every rising edge
// and none can be stalled or dropped, except that reset discards the one
// in flight.
module execute (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  control_in,
  input  logic [4:0]  dest_index_in,
  input  logic [15:0] reg1_data,
  input  logic [15:0] reg2_data,
  input  logic [15:0] npc,
  input  logic [6:0]  immediate,
  output logic [4:0]  dest_index_out,
  output logic [4:0]  control_out,
  output logic [15:0] output_reg,
  output logic [15:0] result_out,
  output logic [15:0] target,
  output logic        DEST_REG_WRITE_EN,
  output logic        ZF,
  output logic        GF,
  output logic        LF
);

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b00101;
  localparam logic [4:0] OP_XOR  = 5'b00110;
  localparam logic [4:0] OP_NOT  = 5'b00111;
  localparam logic [4:0] OP_SLL  = 5'b01000;
  localparam logic [4:0] OP_SRL  = 5'b01001;
  localparam logic [4:0] OP_SRA  = 5'b01010;
  localparam logic [4:0] OP_CMP  = 5'b01011;
  localparam logic [4:0] OP_LI   = 5'b01100;
  localparam logic [4:0] OP_MOV  = 5'b01101;
  localparam logic [4:0] OP_LW   = 5'b01110;
  localparam logic [4:0] OP_SW   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BNE  = 5'b10001;
  localparam logic [4:0] OP_BGT  = 5'b10010;
  localparam logic [4:0] OP_BLT  = 5'b10011;
  localparam logic [4:0] OP_JMP  = 5'b10100;
  localparam logic [4:0] OP_JR   = 5'b10101;
  localparam logic [4:0] OP_JAL  = 5'b10110;

  logic [15:0] w_simm;
  logic [15:0] w_r1_plus_imm;
  logic [15:0] w_npc_plus_imm;
  logic [3:0]  w_shamt;
  logic [15:0] w_sra;
  logic        w_eq;
  logic        w_gt;
  logic        w_lt;
  logic [15:0] w_result;
  logic [15:0] w_target;
  logic        w_we;
  logic        w_flag_upd;

  assign w_simm         = {{9{immediate[6]}}, immediate};
  assign w_r1_plus_imm  = reg1_data + w_simm;
  assign w_npc_plus_imm = npc + w_simm;
  assign w_shamt        = reg2_data[3:0];
  assign w_sra          = $signed(reg1_data) >>> w_shamt;

  // Signed comparison of the two operands; exactly one of these is set.
  assign w_eq = (reg1_data == reg2_data);
  assign w_gt = ($signed(reg1_data) > $signed(reg2_data));
  assign w_lt = ($signed(reg1_data) < $signed(reg2_data));

  // Opcode decode: result, target, write enable and whether flags update.
  // Undefined opcodes fall through to the NOP defaults.
  always_comb begin
    w_result   = 16'h0000;
    w_target   = 16'h0000;
    w_we       = 1'b0;
    w_flag_upd = 1'b0;
    case (control_in)
      OP_NOP:  ;
      OP_SUB:  begin w_result = reg1_data - reg2_data; w_we = 1'b1; w_flag_upd = 1'b1; end
      OP_ADD:  begin w_result = reg1_data + reg2_data; w_we = 1'b1; end
      OP_ADDI: begin w_result = w_r1_plus_imm;         w_we = 1'b1; end
      OP_AND:  begin w_result = reg1_data & reg2_data; w_we = 1'b1; end
      OP_OR:   begin w_result = reg1_data | reg2_data; w_we = 1'b1; end
      OP_XOR:  begin w_result = reg1_data ^ reg2_data; w_we = 1'b1; end
      OP_NOT:  begin w_result = ~reg1_data;            w_we = 1'b1; end
      OP_SLL:  begin w_result = reg1_data << w_shamt;  w_we = 1'b1; end
      OP_SRL:  begin w_result = reg1_data >> w_shamt;  w_we = 1'b1; end
      OP_SRA:  begin w_result = w_sra;                 w_we = 1'b1; end
      OP_CMP:  w_flag_upd = 1'b1;
      OP_LI:   begin w_result = w_simm;                w_we = 1'b1; end
      OP_MOV:  begin w_result = reg1_data;             w_we = 1'b1; end
      OP_LW:   begin w_result = w_r1_plus_imm;         w_we = 1'b1; end
      OP_SW:   w_result = w_r1_plus_imm;
      OP_BEQ, OP_BNE, OP_BGT, OP_BLT: begin
        w_target   = w_npc_plus_imm;
        w_flag_upd = 1'b1;
      end
      OP_JMP:  w_target = w_npc_plus_imm;
      OP_JR:   w_target = reg1_data;
      OP_JAL:  begin w_result = npc; w_target = w_npc_plus_imm; w_we = 1'b1; end
      default: ;
    endcase
  end

  // EX/MEM pipeline register; flags hold unless the opcode compares.
  always_ff @(posedge clk) begin
    if (reset) begin
      dest_index_out    <= 5'd0;
      control_out       <= 5'd0;
      output_reg        <= 16'h0000;
      result_out        <= 16'h0000;
      target            <= 16'h0000;
      DEST_REG_WRITE_EN <= 1'b0;
      ZF                <= 1'b0;
      GF                <= 1'b0;
      LF                <= 1'b0;
    end else begin
      dest_index_out    <= dest_index_in;
      control_out       <= control_in;
      output_reg        <= reg2_data;
      result_out        <= w_result;
      target            <= w_target;
      DEST_REG_WRITE_EN <= w_we;
      if (w_flag_upd) begin
        ZF <= w_eq;
        GF <= w_gt;
        LF <= w_lt;
      end
    end
  end

endmodule

// File: tb/tb_execute.sv
// Bench for the execute stage: directed vector table, hand-written reset
// sequences, then randomized instructions checked against a reference model.
module tb_execute;

  logic        clk;
  logic        reset;
  logic [4:0]  control_in;
  logic [4:0]  dest_index_in;
  logic [15:0] reg1_data;
  logic [15:0] reg2_data;
  logic [15:0] npc;
  logic [6:0]  immediate;
  logic [4:0]  dest_index_out;
  logic [4:0]  control_out;
  logic [15:0] output_reg;
  logic [15:0] result_out;
  logic [15:0] target;
  logic        DEST_REG_WRITE_EN;
  logic        ZF, GF, LF;

  execute dut (
    .clk(clk), .reset(reset),
    .control_in(control_in), .dest_index_in(dest_index_in),
    .reg1_data(reg1_data), .reg2_data(reg2_data),
    .npc(npc), .immediate(immediate),
    .dest_index_out(dest_index_out), .control_out(control_out),
    .output_reg(output_reg), .result_out(result_out), .target(target),
    .DEST_REG_WRITE_EN(DEST_REG_WRITE_EN),
    .ZF(ZF), .GF(GF), .LF(LF)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Driver: apply one instruction after the falling edge, return #1 after the rising edge.
  task automatic drive(input logic rst, input logic [4:0] op, input logic [4:0] dst,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] pc, input logic [6:0] imm);
    @(negedge clk);
    reset = rst; control_in = op; dest_index_in = dst;
    reg1_data = a; reg2_data = b; npc = pc; immediate = imm;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [4:0] e_dst, input logic [4:0] e_ctl,
                           input logic [15:0] e_oreg, input logic [15:0] e_res,
                           input logic [15:0] e_tgt, input logic e_we, input logic [2:0] e_flags);
    check({tag, ".dest"},   32'(dest_index_out), 32'(e_dst));
    check({tag, ".ctrl"},   32'(control_out), 32'(e_ctl));
    check({tag, ".oreg"},   32'(output_reg), 32'(e_oreg));
    check({tag, ".result"}, 32'(result_out), 32'(e_res));
    check({tag, ".target"}, 32'(target), 32'(e_tgt));
    check({tag, ".we"},     32'(DEST_REG_WRITE_EN), 32'(e_we));
    check({tag, ".flags"},  32'({ZF, GF, LF}), 32'(e_flags));
  endtask

  // Directed vector table
  typedef struct {
    logic [4:0]  op;
    logic [4:0]  dst;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] pc;
    logic [6:0]  imm;
    logic [15:0] e_res;
    logic [15:0] e_tgt;
    logic        e_we;
    logic [2:0]  e_flags;   // {ZF, GF, LF}
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic [4:0] op, input logic [4:0] dst,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] pc, input logic [6:0] imm,
                              input logic [15:0] e_res, input logic [15:0] e_tgt,
                              input logic e_we, input logic [2:0] e_flags);
    vec_t v;
    v.op = op; v.dst = dst; v.a = a; v.b = b; v.pc = pc; v.imm = imm;
    v.e_res = e_res; v.e_tgt = e_tgt; v.e_we = e_we; v.e_flags = e_flags;
    return v;
  endfunction

  // Reference model: opcode semantics with plain integer arithmetic.
  logic [2:0] m_flags;   // {ZF, GF, LF}
  localparam int W = 62;
  logic [W-1:0] exp_q[$];

  task automatic model(input logic rst, input logic [4:0] op, input logic [4:0] dst,
                       input logic [15:0] a16, input logic [15:0] b16,
                       input logic [15:0] pc16, input logic [6:0] imm7);
    int a, b, pc, sa, sb, simm, res, tgt, sh;
    logic we;
    a = int'(a16); b = int'(b16); pc = int'(pc16);
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    simm = (int'(imm7) >= 64) ? int'(imm7) - 128 : int'(imm7);
    sh = b % 16;
    res = 0; tgt = 0; we = 1'b0;
    case (int'(op))
      1:  begin res = a - b; we = 1; end
      2:  begin res = a + b; we = 1; end
      3:  begin res = a + simm; we = 1; end
      4:  begin res = a & b; we = 1; end
      5:  begin res = a | b; we = 1; end
      6:  begin res = a ^ b; we = 1; end
      7:  begin res = 65535 - a; we = 1; end
      8:  begin res = a * (1 << sh); we = 1; end
      9:  begin res = a / (1 << sh); we = 1; end
      10: begin res = sa >>> sh; we = 1; end
      12: begin res = simm; we = 1; end
      13: begin res = a; we = 1; end
      14: begin res = a + simm; we = 1; end
      15: res = a + simm;
      16, 17, 18, 19, 20: tgt = pc + simm;
      21: tgt = a;
      22: begin res = pc; tgt = pc + simm; we = 1; end
      default: ;
    endcase
    if (rst) begin
      m_flags = 3'b000;
      exp_q.push_back('0);
    end else begin
      if (op == 5'd1 || op == 5'd11 || (op >= 5'd16 && op <= 5'd19))
        m_flags = {sa == sb, sa > sb, sa < sb};
      exp_q.push_back({dst, op, b16, res[15:0], tgt[15:0], we, m_flags});
    end
  endtask

  initial begin
    logic [W-1:0] e;
    int n_rand;

    vecs[0]  = mk(5'b00001, 5'd2,  16'd10,    16'd3,     16'd0,  7'd0,    16'd7,     16'd0,   1'b1, 3'b010);
    vecs[1]  = mk(5'b00010, 5'd3,  16'd10,    16'd5,     16'd0,  7'd0,    16'd15,    16'd0,   1'b1, 3'b010);
    vecs[2]  = mk(5'b00011, 5'd4,  16'd10,    16'd0,     16'd0,  7'd7,    16'd17,    16'd0,   1'b1, 3'b010);
    vecs[3]  = mk(5'b00011, 5'd4,  16'd10,    16'd0,     16'd0,  7'h7F,   16'd9,     16'd0,   1'b1, 3'b010);
    vecs[4]  = mk(5'b00010, 5'd5,  16'hFFFF,  16'd1,     16'd0,  7'd0,    16'd0,     16'd0,   1'b1, 3'b010);
    vecs[5]  = mk(5'b01011, 5'd6,  16'hFFFF,  16'd1,     16'd0,  7'd0,    16'd0,     16'd0,   1'b0, 3'b001);
    vecs[6]  = mk(5'b01011, 5'd6,  16'd5,     16'd5,     16'd0,  7'd0,    16'd0,     16'd0,   1'b0, 3'b100);
    vecs[7]  = mk(5'b01111, 5'd7,  16'd100,   16'hABCD,  16'd0,  7'h7C,   16'd96,    16'd0,   1'b0, 3'b100);
    vecs[8]  = mk(5'b10000, 5'd8,  16'd1,     16'd2,     16'd20, 7'h7B,   16'd0,     16'd15,  1'b0, 3'b001);
    vecs[9]  = mk(5'b10110, 5'd15, 16'd0,     16'd0,     16'd40, 7'd8,    16'd40,    16'd48,  1'b1, 3'b001);
    vecs[10] = mk(5'b10101, 5'd0,  16'd300,   16'd9,     16'd50, 7'd3,    16'd0,     16'd300, 1'b0, 3'b001);
    vecs[11] = mk(5'b11111, 5'd9,  16'd5,     16'd6,     16'd7,  7'd3,    16'd0,     16'd0,   1'b0, 3'b001);
    vecs[12] = mk(5'b01010, 5'd10, 16'h8000,  16'h0014,  16'd0,  7'd0,    16'hF800,  16'd0,   1'b1, 3'b001);
    vecs[13] = mk(5'b01100, 5'd11, 16'd0,     16'd0,     16'd0,  7'h40,   16'hFFC0,  16'd0,   1'b1, 3'b001);

    // Reset held with a SUB applied: everything clears.
    drive(1'b1, 5'b00001, 5'd2, 16'd10, 16'd3, 16'd0, 7'd0);
    check_all("reset", 5'd0, 5'd0, 16'h0, 16'h0, 16'h0, 1'b0, 3'b000);

    // Directed table, starting with the first instruction after reset.
    for (int i = 0; i < NVEC; i++) begin
      drive(1'b0, vecs[i].op, vecs[i].dst, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].imm);
      check_all($sformatf("vec%0d", i), vecs[i].dst, vecs[i].op, vecs[i].b,
                vecs[i].e_res, vecs[i].e_tgt, vecs[i].e_we, vecs[i].e_flags);
    end

    // Mid-stream reset discards the in-flight CMP, then MOV proceeds with cleared flags.
    drive(1'b0, 5'b00010, 5'd1, 16'd1, 16'd2, 16'd0, 7'd0);
    check_all("pre_rst_add", 5'd1, 5'b00010, 16'd2, 16'd3, 16'd0, 1'b1, 3'b001);
    drive(1'b1, 5'b01011, 5'd3, 16'd5, 16'd9, 16'd4, 7'd1);
    check_all("mid_rst", 5'd0, 5'd0, 16'h0, 16'h0, 16'h0, 1'b0, 3'b000);
    drive(1'b0, 5'b01101, 5'd12, 16'h1234, 16'h0042, 16'd0, 7'd0);
    check_all("post_rst_mov", 5'd12, 5'b01101, 16'h0042, 16'h1234, 16'd0, 1'b1, 3'b000);

    // Randomized phase against the reference model.
    m_flags = 3'b000;
    n_rand = 400;
    for (int i = 0; i < n_rand; i++) begin
      logic        rst;
      logic [4:0]  op, dst;
      logic [15:0] a, b, pc;
      logic [6:0]  imm;
      rst = ($urandom_range(0, 19) == 0);
      op  = 5'($urandom_range(0, 31));
      dst = 5'($urandom_range(0, 31));
      a   = ($urandom_range(0, 3) == 0) ? b : 16'($urandom);
      b   = ($urandom_range(0, 4) == 0) ? a : 16'($urandom);
      pc  = 16'($urandom);
      imm = 7'($urandom_range(0, 127));
      model(rst, op, dst, a, b, pc, imm);
      drive(rst, op, dst, a, b, pc, imm);
      e = exp_q.pop_front();
      check_all($sformatf("rand%0d", i), e[61:57], e[56:52], e[51:36], e[35:20],
                e[19:4], e[3], e[2:0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
